// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the wait-state data-memory responder:
//   - responder FSM state encoding
//   - data word width
//   - byte-offset alignment mask and a misalignment helper
// -----------------------------------------------------------------------------
package mem_pkg;

  // Responder FSM states; encodings are fixed so waveforms read the same
  // across all users of this package.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  localparam int WORD_BITS = 32;

  // Byte-offset bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // True when the byte offset does not point at the start of a word.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return ((byte_off & ALIGN_MASK) != 2'b00);
  endfunction

endpackage : mem_pkg

// File: rtl/word_ram.sv
// -----------------------------------------------------------------------------
// word_ram
// Single-port-style word array with a synchronous write and a combinational
// read. The parent registers the read data at its own commit point, so no
// output register lives here. Contents are never cleared.
//
// Ports:
//   clk    in   system clock, write happens on rising edge
//   we     in   write enable
//   waddr  in   word index for writes
//   raddr  in   word index for reads
//   wdata  in   word to store
//   rdata  out  word currently stored at raddr
// -----------------------------------------------------------------------------
module word_ram
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [ADDR_BITS-1:0] raddr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WORD_BITS-1:0] mem_q [DEPTH];

  // Array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : word_ram

// File: rtl/wait_state_mem.sv
// -----------------------------------------------------------------------------
// wait_state_mem
// Slave end of the CPU load/store interface. Accepts one word read or write
// per transaction over a valid/ready channel, waits WAIT_CYCLES cycles, then
// returns a one-cycle response. Misaligned accesses never touch the array and
// respond with resp_err=1 and zero data.
//
// Parameters:
//   ADDR_BITS    log2 of the word count of the array
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports:
//   clk         in   system clock, all state changes on rising edge
//   reset       in   synchronous, active-high reset
//   req_valid   in   requester presents a transaction
//   req_ready   out  responder can accept this cycle (IDLE and not in reset)
//   req_write   in   1 = store word, 0 = load word
//   req_addr    in   byte address; bits above ADDR_BITS+1 are ignored
//   req_wdata   in   store data
//   resp_valid  out  one-cycle completion pulse
//   resp_rdata  out  load data, meaningful while resp_valid is high
//   resp_err    out  misaligned flag, meaningful while resp_valid is high
// -----------------------------------------------------------------------------
module wait_state_mem
  import mem_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int CNT_BITS = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(WAIT_LOAD);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam int AW = ADDR_BITS + 2;

  mem_state_e           state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;

  logic                 cap_write_q, cap_write_d;
  logic [AW-1:0]        cap_addr_q, cap_addr_d;
  logic [WORD_BITS-1:0] cap_wdata_q, cap_wdata_d;

  logic                 resp_valid_q, resp_valid_d;
  logic [WORD_BITS-1:0] resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;

  logic                 accept_s;
  logic                 cap_en_s;
  logic                 commit_s;
  logic                 commit_ok_s;
  logic                 use_live_s;
  logic                 sel_write_s;
  logic [AW-1:0]        sel_addr_s;
  logic [WORD_BITS-1:0] sel_wdata_s;
  logic                 sel_mis_s;
  logic [ADDR_BITS-1:0] sel_idx_s;
  logic                 ram_we_s;
  logic [WORD_BITS-1:0] ram_rdata_s;

  // Upper address bits only select aliases of the same word.
  logic                 unused_addr_s;
  assign unused_addr_s = ^req_addr[31:AW];

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept_s  = req_valid && req_ready;

  // With zero wait states the commit edge is the acceptance edge itself, so
  // the live request is used before it has been captured.
  assign use_live_s  = (state_q == ST_IDLE);
  assign sel_write_s = use_live_s ? req_write         : cap_write_q;
  assign sel_addr_s  = use_live_s ? req_addr[AW-1:0]  : cap_addr_q;
  assign sel_wdata_s = use_live_s ? req_wdata         : cap_wdata_q;
  assign sel_mis_s   = is_misaligned(sel_addr_s[1:0]);
  assign sel_idx_s   = sel_addr_s[AW-1:2];

  // Reset drops a pending transaction, so a store must never land then.
  assign commit_ok_s = commit_s && !reset;
  assign ram_we_s    = commit_ok_s && sel_write_s && !sel_mis_s;

  word_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (sel_idx_s),
    .raddr (sel_idx_s),
    .wdata (sel_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Next-state, wait counter and commit decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    cap_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          cap_en_s = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d  = ST_RESP;
            commit_s = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_ZERO) begin
          state_d  = ST_RESP;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture of the accepted request so the requester may move on.
  always_comb begin
    cap_write_d = cap_write_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    if (cap_en_s) begin
      cap_write_d = req_write;
      cap_addr_d  = req_addr[AW-1:0];
      cap_wdata_d = req_wdata;
    end else begin
      cap_write_d = cap_write_q;
      cap_addr_d  = cap_addr_q;
      cap_wdata_d = cap_wdata_q;
    end
  end

  // Response payload: updated only on the commit edge, held otherwise.
  always_comb begin
    resp_valid_d = commit_ok_s;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (commit_ok_s) begin
      if (sel_mis_s) begin
        resp_rdata_d = 32'h0000_0000;
        resp_err_d   = 1'b1;
      end else if (sel_write_s) begin
        resp_rdata_d = 32'h0000_0000;
        resp_err_d   = 1'b0;
      end else begin
        resp_rdata_d = ram_rdata_s;
        resp_err_d   = 1'b0;
      end
    end else begin
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
    end
  end

  // State, counter, capture and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      cap_write_q  <= 1'b0;
      cap_addr_q   <= {AW{1'b0}};
      cap_wdata_q  <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_write_q  <= cap_write_d;
      cap_addr_q   <= cap_addr_d;
      cap_wdata_q  <= cap_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule : wait_state_mem

// File: tb/tb_wait_state_mem.sv
// -----------------------------------------------------------------------------
// tb_wait_state_mem
// Two responders share clock and reset: dut_a with two wait states and dut_z
// with none. Expected data comes from word-array models indexed by
// (byte address / 4) mod 1024, updated when a store completes.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wait_state_mem;

  localparam int WAIT_A = 2;

  logic        clk;
  logic        reset;

  logic        a_valid, a_ready, a_write, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        z_valid, z_ready, z_write, z_rvalid, z_err;
  logic [31:0] z_addr, z_wdata, z_rdata;

  int n_checks;
  int n_fail;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_z [1024];

  logic [31:0] zq_rd[$];
  logic        zq_err[$];
  int          zq_edge[$];
  int          z_edge;

  wait_state_mem #(.ADDR_BITS(10), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err)
  );

  wait_state_mem #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
    .req_addr(z_addr), .req_wdata(z_wdata),
    .resp_valid(z_rvalid), .resp_rdata(z_rdata), .resp_err(z_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transaction on dut_a, checked against mem_a.
  task automatic txn_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input string tag);
    int          k;
    int          idx;
    logic        mis;
    logic [31:0] exp_rd;
    mis    = (addr % 4) != 0;
    idx    = int'((addr / 4) % 1024);
    exp_rd = (wr || mis) ? 32'h0 : mem_a[idx];
    k = 0;
    while (!a_ready && k < 20) begin
      @(posedge clk); @(negedge clk); k++;
    end
    check_eq({tag, "_rdy"}, {31'd0, a_ready}, 32'd1);
    a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wdata;
    @(posedge clk); @(negedge clk);
    // Inputs after acceptance must have no effect.
    a_valid = 1'b0; a_write = 1'($urandom); a_addr = $urandom; a_wdata = $urandom;
    check_eq({tag, "_busy"}, {31'd0, a_ready}, 32'd0);
    k = 0;
    while (!a_rvalid && k < 20) begin
      @(posedge clk); @(negedge clk); k++;
    end
    check_eq({tag, "_lat"}, 32'(k), 32'(WAIT_A));
    check_eq({tag, "_rdata"}, a_rdata, exp_rd);
    check_eq({tag, "_err"}, {31'd0, a_err}, {31'd0, mis});
    if (wr && !mis) mem_a[idx] = wdata;
    @(posedge clk); @(negedge clk);
    check_eq({tag, "_pulse"}, {31'd0, a_rvalid}, 32'd0);
    check_eq({tag, "_idle"}, {31'd0, a_ready}, 32'd1);
  endtask

  // Pop and compare one dut_z response against the oldest expectation.
  task automatic check_resp_z(input string tag);
    check_eq({tag, "_expq"}, 32'(zq_rd.size()), 32'd1);
    if (zq_rd.size() > 0) begin
      check_eq({tag, "_rdata"}, z_rdata, zq_rd.pop_front());
      check_eq({tag, "_err"}, {31'd0, z_err}, {31'd0, zq_err.pop_front()});
      check_eq({tag, "_edge"}, 32'(z_edge), 32'(zq_edge.pop_front()));
    end
  endtask

  // Hold req_valid high on dut_z for ncyc cycles; mode 0 = aligned stores
  // sweeping indices 0..5, 1 = loads, 2 = random mix including misaligned.
  task automatic stream_z(input int ncyc, input int mode, input string tag);
    int          acc;
    int          idx;
    logic        wr;
    logic        mis;
    logic [31:0] addr;
    logic [31:0] wd;
    acc = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (z_rvalid) check_resp_z(tag);
      z_valid = 1'b1;
      if (z_ready) begin
        idx  = (mode == 0) ? (acc % 6) : int'($urandom_range(0, 5));
        wr   = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'b0 : 1'($urandom));
        addr = ($urandom_range(0, 1023) << 12) | (32'(idx) << 2);
        if (mode == 2 && $urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
        wd   = $urandom;
        mis  = (addr % 4) != 0;
        z_write = wr; z_addr = addr; z_wdata = wd;
        zq_rd.push_back((wr || mis) ? 32'h0 : mem_z[idx]);
        zq_err.push_back(mis);
        zq_edge.push_back(z_edge + 1);
        if (wr && !mis) mem_z[idx] = wd;
        acc++;
      end else begin
        z_write = 1'($urandom); z_addr = $urandom; z_wdata = $urandom;
      end
      @(posedge clk); z_edge++; @(negedge clk);
    end
    z_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (z_rvalid) check_resp_z(tag);
      @(posedge clk); z_edge++; @(negedge clk);
    end
    check_eq({tag, "_accepts"}, 32'(acc), 32'(ncyc / 2));
    check_eq({tag, "_drained"}, 32'(zq_rd.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          pool [4];
    int          idx;
    logic [31:0] addr;
    n_checks = 0; n_fail = 0; z_edge = 0;
    pool[0] = 4; pool[1] = 5; pool[2] = 8; pool[3] = 1023;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'h0; mem_z[i] = 32'h0;
    end
    reset = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    z_valid = 1'b0; z_write = 1'b0; z_addr = 32'h0; z_wdata = 32'h0;

    // Reset held for three cycles, requests offered meanwhile.
    a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_ready", {31'd0, a_ready}, 32'd0);
      check_eq("rst_rvalid", {31'd0, a_rvalid}, 32'd0);
      check_eq("rst_rdata", a_rdata, 32'h0);
      check_eq("rst_z_ready", {31'd0, z_ready}, 32'd0);
    end
    a_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("post_rst_ready", {31'd0, a_ready}, 32'd1);
    check_eq("post_rst_rvalid", {31'd0, a_rvalid}, 32'd0);

    // Store then load, misaligned load, address wrap.
    txn_a(1'b1, 32'h10, 32'hDEADBEEF, "st10");
    txn_a(1'b0, 32'h10, 32'h0, "ld10");
    txn_a(1'b0, 32'h13, 32'h0, "ld13_mis");
    txn_a(1'b1, 32'h13, 32'h0BADF00D, "st13_mis");
    txn_a(1'b0, 32'h10, 32'h0, "ld10_again");
    txn_a(1'b1, 32'h1010, 32'h12345678, "st1010_wrap");
    txn_a(1'b0, 32'h10, 32'h0, "ld10_wrap");

    // Reset during BUSY drops the pending store.
    txn_a(1'b1, 32'h20, 32'h11111111, "st20_pre");
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'hAAAA5555;
    @(posedge clk); @(negedge clk);
    a_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("busy_rst_ready", {31'd0, a_ready}, 32'd0);
    check_eq("busy_rst_rvalid", {31'd0, a_rvalid}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check_eq("busy_rst_quiet", {31'd0, a_rvalid}, 32'd0);
      check_eq("busy_rst_idle", {31'd0, a_ready}, 32'd1);
    end
    txn_a(1'b0, 32'h20, 32'h0, "ld20_after_rst");

    // Randomized traffic over a small index pool with random alias bits.
    for (int i = 0; i < 4; i++) txn_a(1'b1, 32'(pool[i]) << 2, $urandom, "rnd_init");
    for (int i = 0; i < 24; i++) begin
      idx  = pool[$urandom_range(0, 3)];
      addr = ($urandom_range(0, 1023) << 12) | (32'(idx) << 2);
      if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
      txn_a(1'($urandom), addr, $urandom, "rnd");
    end

    // Zero wait states with req_valid held high.
    stream_z(12, 0, "z_fill");
    stream_z(6, 1, "z_hold6");
    stream_z(30, 2, "z_mix");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wait_state_mem
